// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
//
// Pipeline decode stage that sits directly in front of an 8 x 16-bit register
// file (r0 reads as zero, one-cycle synchronous read). The fetched instruction
// is split into fields. The register-file read addresses are driven
// combinationally, so read data comes back in the same cycle that the
// registered decode outputs become visible.
//
// A small writeback bypass corrects reads that collide with a same-cycle
// write. A load-use interlock inserts a single bubble. Downstream stall and
// flush are honoured.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid/in_instr/in_pc   instruction presented by fetch
//   flush                 squash the instruction held in decode
//   ex_stall              downstream cannot accept; hold everything
//   stall_out             fetch must hold its instruction
//   raddr0/raddr1         register file read addresses (combinational)
//   rdata0/rdata1         register file read data (one cycle after address)
//   wb_wen/wb_waddr/wb_wdata  writeback port, shared with the register file
//   out_*                 decoded instruction; meaningful only when out_valid=1
// ----------------------------------------------------------------------------
module decode_stage #(
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_pc,
  input  logic        flush,
  input  logic        ex_stall,
  output logic        stall_out,
  output logic [2:0]  raddr0,
  output logic [2:0]  raddr1,
  input  logic [15:0] rdata0,
  input  logic [15:0] rdata1,
  input  logic        wb_wen,
  input  logic [2:0]  wb_waddr,
  input  logic [15:0] wb_wdata,
  output logic        out_valid,
  output logic [2:0]  out_opcode,
  output logic [2:0]  out_dest,
  output logic [15:0] out_op0,
  output logic [15:0] out_op1,
  output logic [15:0] out_imm,
  output logic [15:0] out_pc
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  // Source register pair {r0, r1}; an unused source reads register 0.
  function automatic logic [5:0] decode_srcs(input logic [15:0] instr);
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] rc;
    ra = instr[12:10];
    rb = instr[9:7];
    rc = instr[2:0];
    case (instr[15:13])
      OP_ADD, OP_NAND:          decode_srcs = {rb, rc};
      OP_ADDI, OP_LW, OP_JALR:  decode_srcs = {rb, 3'd0};
      OP_SW:                    decode_srcs = {rb, ra};
      OP_BEQ:                   decode_srcs = {ra, rb};
      default:                  decode_srcs = 6'd0;   // lui reads nothing
    endcase
  endfunction

  // Destination register; 0 for instructions that write nothing.
  function automatic logic [2:0] decode_dest(input logic [15:0] instr);
    case (instr[15:13])
      OP_SW, OP_BEQ: decode_dest = 3'd0;
      default:       decode_dest = instr[12:10];
    endcase
  endfunction

  function automatic logic [15:0] decode_imm(input logic [15:0] instr);
    case (instr[15:13])
      OP_ADDI, OP_SW, OP_LW, OP_BEQ: decode_imm = {{9{instr[6]}}, instr[6:0]};
      OP_LUI:                        decode_imm = {instr[9:0], 6'b0};
      default:                       decode_imm = 16'd0;
    endcase
  endfunction

  // Instruction currently occupying decode (the one the out_* describe).
  logic [15:0] instr_reg;

  logic        out_valid_reg;
  logic [2:0]  out_opcode_reg;
  logic [2:0]  out_dest_reg;
  logic [15:0] out_imm_reg;
  logic [15:0] out_pc_reg;

  // Operands are forced to zero from reset until the first clock edge after
  // it, because rdata is not under this block's reset.
  logic        ops_live_reg;

  logic        sel;
  logic [15:0] src_instr;
  logic [5:0]  src_regs;
  logic [5:0]  in_regs;
  logic        load_use;

  // Hazard check uses the incoming instruction's own sources, never src,
  // so stall_out has no combinational path back into itself.
  assign in_regs  = decode_srcs(in_instr);

  assign load_use = out_valid_reg && (out_opcode_reg == OP_LW) &&
                    (out_dest_reg != 3'd0) && in_valid &&
                    ((in_regs[5:3] == out_dest_reg) ||
                     (in_regs[2:0] == out_dest_reg));

  assign stall_out = ex_stall | load_use;

  // While stalled, re-read the held instruction's sources every cycle so the
  // operands track writes that land during the stall.
  assign sel       = !stall_out;
  assign src_instr = sel ? in_instr : instr_reg;
  assign src_regs  = decode_srcs(src_instr);

  assign raddr0 = src_regs[5:3];
  assign raddr1 = src_regs[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_opcode_reg <= 3'd0;
      out_dest_reg   <= 3'd0;
      out_imm_reg    <= 16'd0;
      out_pc_reg     <= 16'd0;
      instr_reg      <= NOP_INSTR;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      instr_reg      <= NOP_INSTR;
    end else if (ex_stall) begin
      // hold everything
    end else if (load_use) begin
      // one bubble; the lw stays recorded but no longer valid, which
      // clears the hazard on the next cycle
      out_valid_reg  <= 1'b0;
    end else begin
      out_valid_reg  <= in_valid;
      out_opcode_reg <= src_instr[15:13];
      out_dest_reg   <= decode_dest(src_instr);
      out_imm_reg    <= decode_imm(src_instr);
      out_pc_reg     <= in_pc;
      instr_reg      <= in_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_live_reg <= 1'b0;
    end else begin
      ops_live_reg <= 1'b1;
    end
  end

  // Writeback bypass, one per read port. The register file returns the
  // pre-write value when a read and a write to the same address share an
  // edge, so that write is captured here and substituted for rdata.
  logic [2:0]  raddr [2];
  logic [15:0] rdata [2];
  logic [15:0] op    [2];

  assign raddr[0] = raddr0;
  assign raddr[1] = raddr1;
  assign rdata[0] = rdata0;
  assign rdata[1] = rdata1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_byp
      logic        hit_reg;
      logic [15:0] data_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hit_reg  <= 1'b0;
          data_reg <= 16'd0;
        end else if (flush) begin
          hit_reg  <= 1'b0;
        end else begin
          hit_reg  <= wb_wen && (wb_waddr == raddr[gi]) && (raddr[gi] != 3'd0);
          data_reg <= wb_wdata;
        end
      end

      assign op[gi] = !ops_live_reg ? 16'd0 :
                      hit_reg       ? data_reg : rdata[gi];
    end
  endgenerate

  assign out_valid  = out_valid_reg;
  assign out_opcode = out_opcode_reg;
  assign out_dest   = out_dest_reg;
  assign out_imm    = out_imm_reg;
  assign out_pc     = out_pc_reg;
  assign out_op0    = op[0];
  assign out_op1    = op[1];

endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
//
// Directed bench for decode_stage with a behavioural 8 x 16 register file
// (r0 reads zero, synchronous read returning the pre-write value on a
// same-edge write). Accepted instructions push their expected decode into a
// scoreboard queue; the entry is popped and compared when the DUT presents it.
// ----------------------------------------------------------------------------
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = 16'd0;
  logic [15:0] in_pc = 16'd0;
  logic        flush = 1'b0;
  logic        ex_stall = 1'b0;
  logic        stall_out;
  logic [2:0]  raddr0;
  logic [2:0]  raddr1;
  logic [15:0] rdata0;
  logic [15:0] rdata1;
  logic        wb_wen = 1'b0;
  logic [2:0]  wb_waddr = 3'd0;
  logic [15:0] wb_wdata = 16'd0;
  logic        out_valid;
  logic [2:0]  out_opcode;
  logic [2:0]  out_dest;
  logic [15:0] out_op0;
  logic [15:0] out_op1;
  logic [15:0] out_imm;
  logic [15:0] out_pc;

  always #5 clk = ~clk;

  decode_stage #(.NOP_INSTR(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .flush      (flush),
    .ex_stall   (ex_stall),
    .stall_out  (stall_out),
    .raddr0     (raddr0),
    .raddr1     (raddr1),
    .rdata0     (rdata0),
    .rdata1     (rdata1),
    .wb_wen     (wb_wen),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .out_valid  (out_valid),
    .out_opcode (out_opcode),
    .out_dest   (out_dest),
    .out_op0    (out_op0),
    .out_op1    (out_op1),
    .out_imm    (out_imm),
    .out_pc     (out_pc)
  );

  // ---------------- register file model ----------------
  function automatic logic [15:0] init_val(input int i);
    case (i)
      1: init_val = 16'd11;
      2: init_val = 16'd5;
      3: init_val = 16'd7;
      4: init_val = 16'd2;
      5: init_val = 16'h0055;
      6: init_val = 16'h0066;
      7: init_val = 16'h0077;
      default: init_val = 16'd0;
    endcase
  endfunction

  logic [15:0] rf [8];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= init_val(i);
    end else if (wb_wen && wb_waddr != 3'd0) begin
      rf[wb_waddr] <= wb_wdata;
    end
    rdata0 <= (raddr0 == 3'd0) ? 16'd0 : rf[raddr0];
    rdata1 <= (raddr1 == 3'd0) ? 16'd0 : rf[raddr1];
  end

  // ---------------- scoreboard and checking ----------------
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  dest;
    logic [15:0] op0;
    logic [15:0] op1;
    logic [15:0] imm;
    logic [15:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a valid instruction and record what decode should make of it.
  task automatic accept(input logic [15:0] instr, input logic [15:0] pc,
                        input logic [2:0] opc, input logic [2:0] dst,
                        input logic [15:0] op0, input logic [15:0] op1,
                        input logic [15:0] imm);
    exp_t e;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    e.opcode = opc;
    e.dest   = dst;
    e.op0    = op0;
    e.op1    = op1;
    e.imm    = imm;
    e.pc     = pc;
    sb_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_valid"},  16'(out_valid),  16'd1);
    check({tag, "_opcode"}, 16'(out_opcode), 16'(e.opcode));
    check({tag, "_dest"},   16'(out_dest),   16'(e.dest));
    check({tag, "_op0"},    out_op0,         e.op0);
    check({tag, "_op1"},    out_op1,         e.op1);
    check({tag, "_imm"},    out_imm,         e.imm);
    check({tag, "_pc"},     out_pc,          e.pc);
    $display("txn %s: opcode=%0d dest=%0d op0=%h op1=%h imm=%h pc=%h",
             tag, out_opcode, out_dest, out_op0, out_op1, out_imm, out_pc);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_dest",  16'(out_dest),  16'd0);
    check("rst_op0",   out_op0,        16'd0);
    check("rst_imm",   out_imm,        16'd0);
    check("rst_stall", 16'(stall_out), 16'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();                                   // empty advance
    check("idle_valid", 16'(out_valid), 16'd0);

    // add r1,r2,r3
    accept(16'h0503, 16'h0010, 3'b000, 3'd1, 16'd5, 16'd7, 16'd0);
    #1;
    check("add_raddr0", 16'(raddr0), 16'd2);
    check("add_raddr1", 16'(raddr1), 16'd3);
    check("add_stall",  16'(stall_out), 16'd0);
    tick();
    check_out("add");

    // addi r4,r4,-1 with a same-cycle write of 9 to r4 (file holds 2)
    accept(16'h327F, 16'h0012, 3'b001, 3'd4, 16'd9, 16'd0, 16'hFFFF);
    wb_wen = 1'b1; wb_waddr = 3'd4; wb_wdata = 16'd9;
    #1;
    check("addi_raddr0", 16'(raddr0), 16'd4);
    tick();
    wb_wen = 1'b0;
    check_out("addi_byp");

    // lw r2,0(r1) then add r3,r2,r0 -> one bubble
    accept(16'hA880, 16'h0014, 3'b101, 3'd2, 16'd11, 16'd0, 16'd0);
    #1;
    check("lw_stall", 16'(stall_out), 16'd0);
    tick();
    check_out("lw");
    in_valid = 1'b1; in_instr = 16'h0D00; in_pc = 16'h0016;
    #1;
    check("lu_stall", 16'(stall_out), 16'd1);
    tick();
    check("lu_bubble", 16'(out_valid), 16'd0);
    #1;
    check("lu_clear",  16'(stall_out), 16'd0);
    check("lu_raddr0", 16'(raddr0),    16'd2);
    accept(16'h0D00, 16'h0016, 3'b000, 3'd3, 16'd5, 16'd0, 16'd0);
    tick();
    check_out("lu_add");

    // nand r6,r5,r7 then 3 cycles of ex_stall; r5 written in stall cycle 2
    accept(16'h5A87, 16'h0018, 3'b010, 3'd6, 16'h0055, 16'h0077, 16'd0);
    tick();
    check_out("nand");
    ex_stall = 1'b1;
    in_valid = 1'b1; in_instr = 16'h0503; in_pc = 16'h001A;
    #1;
    check("stl_raddr0", 16'(raddr0),    16'd5);
    check("stl_stall",  16'(stall_out), 16'd1);
    tick();
    check("stl1_op0", out_op0, 16'h0055);
    check("stl1_pc",  out_pc,  16'h0018);
    wb_wen = 1'b1; wb_waddr = 3'd5; wb_wdata = 16'hABCD;
    tick();
    wb_wen = 1'b0;
    check("stl2_op0",  out_op0,         16'hABCD);
    check("stl2_dest", 16'(out_dest),   16'd6);
    check("stl2_valid", 16'(out_valid), 16'd1);
    tick();
    check("stl3_op0",    out_op0,      16'hABCD);
    check("stl3_raddr0", 16'(raddr0),  16'd5);
    check("stl3_op1",    out_op1,      16'h0077);
    ex_stall = 1'b0;
    accept(16'h0503, 16'h001A, 3'b000, 3'd1, 16'd5, 16'd7, 16'd0);
    tick();
    check_out("post_stall");

    // flush while stalled squashes
    ex_stall = 1'b1; flush = 1'b1;
    in_valid = 1'b1; in_instr = 16'h0503; in_pc = 16'h001C;
    tick();
    check("flush_valid", 16'(out_valid), 16'd0);
    ex_stall = 1'b0; flush = 1'b0;

    // lui r5,0x3FF
    accept(16'h77FF, 16'h0030, 3'b011, 3'd5, 16'd0, 16'd0, 16'hFFC0);
    #1;
    check("lui_raddr0", 16'(raddr0), 16'd0);
    check("lui_raddr1", 16'(raddr1), 16'd0);
    tick();
    check_out("lui");

    // beq r1,r2,+5 ; sw r3,-2(r4) ; jalr r7,r1  (r4 now 9)
    accept(16'hC505, 16'h0032, 3'b110, 3'd0, 16'd11, 16'd5, 16'd5);
    tick();
    check_out("beq");
    accept(16'h8E7E, 16'h0034, 3'b100, 3'd0, 16'd9, 16'd7, 16'hFFFE);
    tick();
    check_out("sw");
    accept(16'hFC80, 16'h0036, 3'b111, 3'd7, 16'd11, 16'd0, 16'd0);
    tick();
    check_out("jalr");

    // asynchronous reset between edges clears outputs at once
    in_valid = 1'b0; in_instr = 16'd0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid",  16'(out_valid),  16'd0);
    check("arst_opcode", 16'(out_opcode), 16'd0);
    check("arst_dest",   16'(out_dest),   16'd0);
    check("arst_op0",    out_op0,         16'd0);
    check("arst_imm",    out_imm,         16'd0);
    check("arst_pc",     out_pc,          16'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline decode stage, directly upstream of the 8×16-bit register file (r0 reads as zero, 1-cycle synchronous read).
- Splits the fetched instruction and drives the register file read addresses combinationally, so read data returns aligned with its registered outputs.
- Corrects read-during-write staleness with a writeback bypass, detects load-use hazards, and honours downstream stall and flush.

Parameters:
- NOP_INSTR, 16'h0000, instruction value held in the instruction register after reset or flush.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  fetch presents a valid instruction
- in_instr  in  16  instruction word
- in_pc  in  16  PC of in_instr
- flush  in  1  squash the instruction in decode (branch/jump redirect)
- ex_stall  in  1  downstream cannot accept; hold all state
- stall_out  out  1  upstream must hold in_instr/in_pc/in_valid
- raddr0  out  3  register file read address 0
- raddr1  out  3  register file read address 1
- rdata0  in  16  register file read data 0 (one cycle after raddr0)
- rdata1  in  16  register file read data 1
- wb_wen  in  1  writeback write enable (same signal as the register file's)
- wb_waddr  in  3  writeback address
- wb_wdata  in  16  writeback data
- out_valid  out  1  decoded instruction valid
- out_opcode  out  3  instr[15:13]
- out_dest  out  3  destination register; 0 if the instruction has none
- out_op0  out  16  operand 0
- out_op1  out  16  operand 1
- out_imm  out  16  extended immediate
- out_pc  out  16  PC of the decoded instruction

Behaviour:
Instruction fields:
- ra = [12:10], rb = [9:7], rc = [2:0], imm7 = [6:0], imm10 = [9:0].

Source selection (src = sel ? in_instr : held instr):
- add/nand (000/010): r0=rb, r1=rc, dest=ra.
- addi (001): r0=rb, r1=0, dest=ra, imm = sext(imm7).
- lui (011): r0=0, r1=0, dest=ra, imm = {imm10, 6'b0}.
- sw (100): r0=rb, r1=ra, dest=0, imm = sext(imm7).
- lw (101): r0=rb, r1=0, dest=ra, imm = sext(imm7).
- beq (110): r0=ra, r1=rb, dest=0, imm = sext(imm7).
- jalr (111): r0=rb, r1=0, dest=ra, imm = 0.

Read address select:
- sel = !stall_out.
- raddr0/raddr1 are combinational from src, so the register file re-reads the held sources every stalled cycle.

Hazard detection:
- load_use = out_valid && out_opcode==lw && out_dest!=0 && in_valid && (in_r0==out_dest || in_r1==out_dest).
- stall_out = ex_stall | load_use (combinational).

Register updates on each edge, priority rst > flush > ex_stall > load_use > advance:
- rst: out_valid=0, all out_* = 0, held instr = NOP_INSTR, bypass flags = 0.
- flush: out_valid=0, held instr = NOP_INSTR; other outputs don't-care; bypass flags = 0.
- ex_stall: all out_* and held instr retain their values; bypass recaptured (see below).
- load_use: out_valid=0 (one bubble); nothing else loads. Next cycle out is not lw, so the hazard clears and the instruction advances.
- advance: load all out_* from src fields, out_valid = in_valid, held instr = in_instr.

Writeback bypass:
- Captured every edge except rst/flush: byp0_hit = wb_wen && wb_waddr==raddr0 && raddr0!=0; byp0_data = wb_wdata. Same for port 1.
- out_op0 = byp0_hit ? byp0_data : rdata0, combinationally; same for op1.
- This covers a write in the same cycle as the read; the register file returns the pre-write value in that case.
- Address 0 never hits; op reads 0.

Latency and boundaries:
- Latency is 1 cycle from in_instr to out_*.
- Outputs are valid only when out_valid=1.
- Flush asserted during ex_stall still squashes.
- Reset mid-stall returns to empty immediately (asynchronous).

Test Plan:
- Reset, then in_instr=16'h0503 (add r1,r2,r3), regfile r2=5, r3=7 → next cycle out_valid=1, dest=1, op0=5, op1=7, raddr0=2, raddr1=3 during the input cycle.
- addi r4,r4,-1 (16'h327F) with wb_wen=1, waddr=4, wdata=9 in the same cycle (regfile r4=2) → op0=9 (bypass), imm=16'hFFFF.
- lw r2,0(r1) then add r3,r2,r0 → stall_out=1 for one cycle, one out_valid=0 bubble, then the add decodes with stall_out=0.
- ex_stall held 3 cycles while a write to a held source lands in cycle 2 → outputs frozen, op reflects the new value from cycle 3 onward, raddr stays at the held source.
- flush with ex_stall=1 → out_valid=0 next cycle; lui r5,0x3FF gives imm=16'hFFC0, op0=op1=0.
- Assert rst mid-stream → out_valid and all out_* = 0 immediately, without waiting for a clock edge.
